// File: rtl/rs_alu_pkg.sv
// Shared constants for the ALU reservation station: bus widths, instruction codes,
// entry layout and the CDB wake-up lookup.
package rs_alu_pkg;

   localparam int INST_W   = 6;
   localparam int ADDR_W   = 32;
   localparam int REGVAL_W = 32;
   localparam int IMM_W    = 32;
   localparam int TAG_W    = 5;

   localparam logic [TAG_W-1:0] NO_TAG = {TAG_W{1'b0}};

   typedef enum logic [INST_W-1:0] {
      INST_NOP  = 6'd0,
      INST_ADD  = 6'd1,
      INST_SUB  = 6'd2,
      INST_ADDI = 6'd3,
      INST_AND  = 6'd4,
      INST_OR   = 6'd5,
      INST_XOR  = 6'd6,
      INST_BEQ  = 6'd7,
      INST_BNE  = 6'd8,
      INST_JAL  = 6'd9
   } inst_code_e;

   typedef struct packed {
      logic [INST_W-1:0]   inst;
      logic [ADDR_W-1:0]   npc;
      logic [IMM_W-1:0]    imme;
      logic [TAG_W-1:0]    dest;
      logic [TAG_W-1:0]    rs1_tag;
      logic [REGVAL_W-1:0] rs1_val;
      logic [TAG_W-1:0]    rs2_tag;
      logic [REGVAL_W-1:0] rs2_val;
   } rs_entry_t;

   localparam int ENTRY_W = $bits(rs_entry_t);

   typedef struct packed {
      logic                hit;
      logic [REGVAL_W-1:0] val;
   } wake_t;

   // A pending tag never matches an idle bus because idle buses carry NO_TAG.
   function automatic wake_t cdb_wake(input logic [TAG_W-1:0]    tag,
                                      input logic [TAG_W-1:0]    alu_tag,
                                      input logic [REGVAL_W-1:0] alu_val,
                                      input logic [TAG_W-1:0]    lsb_tag,
                                      input logic [REGVAL_W-1:0] lsb_val);
      wake_t w;
      if ((tag != NO_TAG) && (tag == alu_tag)) begin
         w.hit = 1'b1;
         w.val = alu_val;
      end else if ((tag != NO_TAG) && (tag == lsb_tag)) begin
         w.hit = 1'b1;
         w.val = lsb_val;
      end else begin
         w.hit = 1'b0;
         w.val = {REGVAL_W{1'b0}};
      end
      return w;
   endfunction

endpackage

// File: rtl/rs_select.sv
// Lowest-index priority encoder over a request vector, returning {found, idx}.
module rs_select
   import rs_alu_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int IDX_W = 4
) (
   input  logic [DEPTH-1:0] req,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   // Scan from the top so the lowest requesting index is the last one written.
   always_comb begin
      found = 1'b0;
      idx   = {IDX_W{1'b0}};
      for (int i = DEPTH - 1; i >= 0; i--) begin
         found = found | req[i];
         idx   = req[i] ? IDX_W'(i) : idx;
      end
   end

endmodule

// File: rtl/rs_alu.sv
// ALU reservation station: holds renamed instructions until operands arrive via the CDBs,
// then issues the lowest-index ready entry. Optional macro: RS_WAKE_BYPASS_EN.
module rs_alu
   import rs_alu_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int IDX_W = 4
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                rdy_in,
   input  logic                flush_in,
   input  logic                disp_valid_in,
   input  logic [INST_W-1:0]   disp_inst_in,
   input  logic [ADDR_W-1:0]   disp_npc_in,
   input  logic [IMM_W-1:0]    disp_imme_in,
   input  logic [TAG_W-1:0]    disp_tag_in,
   input  logic [REGVAL_W-1:0] disp_rs1_val_in,
   input  logic [REGVAL_W-1:0] disp_rs2_val_in,
   input  logic [TAG_W-1:0]    disp_rs1_tag_in,
   input  logic [TAG_W-1:0]    disp_rs2_tag_in,
   output logic                full_out,
   input  logic [TAG_W-1:0]    alu_cdb_tag_in,
   input  logic [REGVAL_W-1:0] alu_cdb_val_in,
   input  logic [TAG_W-1:0]    lsb_cdb_tag_in,
   input  logic [REGVAL_W-1:0] lsb_cdb_val_in,
   output logic [INST_W-1:0]   issue_inst_out,
   output logic [ADDR_W-1:0]   issue_npc_out,
   output logic [REGVAL_W-1:0] issue_rs1_val_out,
   output logic [REGVAL_W-1:0] issue_rs2_val_out,
   output logic [IMM_W-1:0]    issue_imme_out,
   output logic [TAG_W-1:0]    issue_tag_out
);

   logic [DEPTH-1:0]    valid_r;
   rs_entry_t           entry_r [DEPTH];
   wake_t               wake1_s [DEPTH];
   wake_t               wake2_s [DEPTH];
   logic [DEPTH-1:0]    elig_s;
   logic                free_found_s;
   logic [IDX_W-1:0]    free_idx_s;
   logic                sel_found_s;
   logic [IDX_W-1:0]    sel_idx_s;
   wake_t               disp_w1_s;
   wake_t               disp_w2_s;
   rs_entry_t           disp_entry_s;
   logic [REGVAL_W-1:0] sel_rs1_val_s;
   logic [REGVAL_W-1:0] sel_rs2_val_s;

   // Per-entry CDB match and issue eligibility.
   always_comb begin
      elig_s = {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         wake1_s[i] = cdb_wake(entry_r[i].rs1_tag, alu_cdb_tag_in, alu_cdb_val_in,
                               lsb_cdb_tag_in, lsb_cdb_val_in);
         wake2_s[i] = cdb_wake(entry_r[i].rs2_tag, alu_cdb_tag_in, alu_cdb_val_in,
                               lsb_cdb_tag_in, lsb_cdb_val_in);
`ifdef RS_WAKE_BYPASS_EN
         elig_s[i] = valid_r[i] && ((entry_r[i].rs1_tag == NO_TAG) || wake1_s[i].hit)
                                && ((entry_r[i].rs2_tag == NO_TAG) || wake2_s[i].hit);
`else
         elig_s[i] = valid_r[i] && (entry_r[i].rs1_tag == NO_TAG)
                                && (entry_r[i].rs2_tag == NO_TAG);
`endif
      end
   end

   rs_select #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_free_sel (
      .req   (~valid_r),
      .found (free_found_s),
      .idx   (free_idx_s)
   );

   rs_select #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_issue_sel (
      .req   (elig_s),
      .found (sel_found_s),
      .idx   (sel_idx_s)
   );

   assign full_out  = ~free_found_s;
   assign disp_w1_s = cdb_wake(disp_rs1_tag_in, alu_cdb_tag_in, alu_cdb_val_in,
                               lsb_cdb_tag_in, lsb_cdb_val_in);
   assign disp_w2_s = cdb_wake(disp_rs2_tag_in, alu_cdb_tag_in, alu_cdb_val_in,
                               lsb_cdb_tag_in, lsb_cdb_val_in);

   // New entry image, with operands already on a CDB this cycle stored as ready.
   always_comb begin
      disp_entry_s.inst    = disp_inst_in;
      disp_entry_s.npc     = disp_npc_in;
      disp_entry_s.imme    = disp_imme_in;
      disp_entry_s.dest    = disp_tag_in;
      disp_entry_s.rs1_tag = disp_w1_s.hit ? NO_TAG : disp_rs1_tag_in;
      disp_entry_s.rs1_val = disp_w1_s.hit ? disp_w1_s.val : disp_rs1_val_in;
      disp_entry_s.rs2_tag = disp_w2_s.hit ? NO_TAG : disp_rs2_tag_in;
      disp_entry_s.rs2_val = disp_w2_s.hit ? disp_w2_s.val : disp_rs2_val_in;
   end

   // Operand values of the selected entry, forwarding a same-cycle CDB hit when enabled.
   always_comb begin
`ifdef RS_WAKE_BYPASS_EN
      sel_rs1_val_s = (entry_r[sel_idx_s].rs1_tag == NO_TAG) ? entry_r[sel_idx_s].rs1_val
                                                             : wake1_s[sel_idx_s].val;
      sel_rs2_val_s = (entry_r[sel_idx_s].rs2_tag == NO_TAG) ? entry_r[sel_idx_s].rs2_val
                                                             : wake2_s[sel_idx_s].val;
`else
      sel_rs1_val_s = entry_r[sel_idx_s].rs1_val;
      sel_rs2_val_s = entry_r[sel_idx_s].rs2_val;
`endif
   end

   // Entry storage, wake-up capture, dispatch write and issue register.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         valid_r <= {DEPTH{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            entry_r[i] <= {ENTRY_W{1'b0}};
         end
         issue_inst_out    <= {INST_W{1'b0}};
         issue_npc_out     <= {ADDR_W{1'b0}};
         issue_rs1_val_out <= {REGVAL_W{1'b0}};
         issue_rs2_val_out <= {REGVAL_W{1'b0}};
         issue_imme_out    <= {IMM_W{1'b0}};
         issue_tag_out     <= NO_TAG;
      end else if (rdy_in) begin
         if (flush_in) begin
            valid_r           <= {DEPTH{1'b0}};
            issue_inst_out    <= {INST_W{1'b0}};
            issue_npc_out     <= {ADDR_W{1'b0}};
            issue_rs1_val_out <= {REGVAL_W{1'b0}};
            issue_rs2_val_out <= {REGVAL_W{1'b0}};
            issue_imme_out    <= {IMM_W{1'b0}};
            issue_tag_out     <= NO_TAG;
         end else begin
            for (int i = 0; i < DEPTH; i++) begin
               if (valid_r[i] && wake1_s[i].hit) begin
                  entry_r[i].rs1_tag <= NO_TAG;
                  entry_r[i].rs1_val <= wake1_s[i].val;
               end
               if (valid_r[i] && wake2_s[i].hit) begin
                  entry_r[i].rs2_tag <= NO_TAG;
                  entry_r[i].rs2_val <= wake2_s[i].val;
               end
            end
            if (sel_found_s) begin
               valid_r[sel_idx_s] <= 1'b0;
               issue_inst_out     <= entry_r[sel_idx_s].inst;
               issue_npc_out      <= entry_r[sel_idx_s].npc;
               issue_rs1_val_out  <= sel_rs1_val_s;
               issue_rs2_val_out  <= sel_rs2_val_s;
               issue_imme_out     <= entry_r[sel_idx_s].imme;
               issue_tag_out      <= entry_r[sel_idx_s].dest;
            end else begin
               issue_inst_out    <= {INST_W{1'b0}};
               issue_npc_out     <= {ADDR_W{1'b0}};
               issue_rs1_val_out <= {REGVAL_W{1'b0}};
               issue_rs2_val_out <= {REGVAL_W{1'b0}};
               issue_imme_out    <= {IMM_W{1'b0}};
               issue_tag_out     <= NO_TAG;
            end
            // The free slot is never the issuing one, so both writes can land together.
            if (disp_valid_in && free_found_s) begin
               valid_r[free_idx_s] <= 1'b1;
               entry_r[free_idx_s] <= disp_entry_s;
            end
         end
      end
   end

endmodule

// File: tb/tb_rs_alu.sv
// Randomized scoreboard bench for rs_alu against a slot-level reference model.
module tb_rs_alu;
   import rs_alu_pkg::*;

   logic                clk_in = 1'b0;
   logic                rst_in = 1'b0;
   logic                rdy_in, flush_in, disp_valid_in, full_out;
   logic [INST_W-1:0]   disp_inst_in, issue_inst_out;
   logic [ADDR_W-1:0]   disp_npc_in, issue_npc_out;
   logic [IMM_W-1:0]    disp_imme_in, issue_imme_out;
   logic [TAG_W-1:0]    disp_tag_in, disp_rs1_tag_in, disp_rs2_tag_in;
   logic [REGVAL_W-1:0] disp_rs1_val_in, disp_rs2_val_in;
   logic [TAG_W-1:0]    alu_cdb_tag_in, lsb_cdb_tag_in, issue_tag_out;
   logic [REGVAL_W-1:0] alu_cdb_val_in, lsb_cdb_val_in;
   logic [REGVAL_W-1:0] issue_rs1_val_out, issue_rs2_val_out;

   rs_alu dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
      .disp_valid_in(disp_valid_in), .disp_inst_in(disp_inst_in), .disp_npc_in(disp_npc_in),
      .disp_imme_in(disp_imme_in), .disp_tag_in(disp_tag_in),
      .disp_rs1_val_in(disp_rs1_val_in), .disp_rs2_val_in(disp_rs2_val_in),
      .disp_rs1_tag_in(disp_rs1_tag_in), .disp_rs2_tag_in(disp_rs2_tag_in),
      .full_out(full_out),
      .alu_cdb_tag_in(alu_cdb_tag_in), .alu_cdb_val_in(alu_cdb_val_in),
      .lsb_cdb_tag_in(lsb_cdb_tag_in), .lsb_cdb_val_in(lsb_cdb_val_in),
      .issue_inst_out(issue_inst_out), .issue_npc_out(issue_npc_out),
      .issue_rs1_val_out(issue_rs1_val_out), .issue_rs2_val_out(issue_rs2_val_out),
      .issue_imme_out(issue_imme_out), .issue_tag_out(issue_tag_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct packed {
      logic [TAG_W-1:0]    tag;
      logic [INST_W-1:0]   inst;
      logic [ADDR_W-1:0]   npc;
      logic [REGVAL_W-1:0] v1;
      logic [REGVAL_W-1:0] v2;
      logic [IMM_W-1:0]    imm;
   } out_t;

   typedef struct {
      int   cyc;
      out_t o;
   } exp_t;

   typedef struct {
      bit                  v;
      logic [INST_W-1:0]   inst;
      logic [ADDR_W-1:0]   npc;
      logic [IMM_W-1:0]    imm;
      logic [TAG_W-1:0]    dest;
      logic [TAG_W-1:0]    t1;
      logic [REGVAL_W-1:0] v1;
      logic [TAG_W-1:0]    t2;
      logic [REGVAL_W-1:0] v2;
   } slot_t;

   int    checks = 0;
   int    failures = 0;
   int    edge_cnt = 0;
   exp_t  exp_q[$];
   slot_t model[16];
   out_t  last_out = '0;
   out_t  mon_act;
   exp_t  mon_exp;

   always @(posedge clk_in) edge_cnt <= edge_cnt + 1;

   function automatic bit on_cdb(input logic [TAG_W-1:0] t);
      return (t != 0) && ((t == alu_cdb_tag_in) || (t == lsb_cdb_tag_in));
   endfunction

   function automatic logic [REGVAL_W-1:0] cdb_value(input logic [TAG_W-1:0] t);
      return (t == alu_cdb_tag_in) ? alu_cdb_val_in : lsb_cdb_val_in;
   endfunction

   function automatic bit usable(input logic [TAG_W-1:0] t);
`ifdef RS_WAKE_BYPASS_EN
      return (t == 0) || on_cdb(t);
`else
      return (t == 0);
`endif
   endfunction

   function automatic bit model_full();
      for (int i = 0; i < 16; i++) if (!model[i].v) return 1'b0;
      return 1'b1;
   endfunction

   // Predict what the DUT shows after the coming clock edge, given current inputs.
   task automatic model_step();
      out_t o;
      int   sel;
      int   fr;
      o = '0;
      if (!rdy_in) begin
         o = last_out;
      end else if (flush_in) begin
         for (int i = 0; i < 16; i++) model[i].v = 1'b0;
      end else begin
         fr = -1;
         sel = -1;
         for (int i = 0; i < 16; i++) begin
            if (fr < 0 && !model[i].v) fr = i;
            if (sel < 0 && model[i].v && usable(model[i].t1) && usable(model[i].t2)) sel = i;
         end
         if (sel >= 0) begin
            o.tag  = model[sel].dest;
            o.inst = model[sel].inst;
            o.npc  = model[sel].npc;
            o.imm  = model[sel].imm;
            o.v1   = (model[sel].t1 == 0) ? model[sel].v1 : cdb_value(model[sel].t1);
            o.v2   = (model[sel].t2 == 0) ? model[sel].v2 : cdb_value(model[sel].t2);
            model[sel].v = 1'b0;
         end
         for (int i = 0; i < 16; i++) begin
            if (model[i].v && on_cdb(model[i].t1)) begin
               model[i].v1 = cdb_value(model[i].t1);
               model[i].t1 = 0;
            end
            if (model[i].v && on_cdb(model[i].t2)) begin
               model[i].v2 = cdb_value(model[i].t2);
               model[i].t2 = 0;
            end
         end
         if (disp_valid_in && fr >= 0) begin
            model[fr].v    = 1'b1;
            model[fr].inst = disp_inst_in;
            model[fr].npc  = disp_npc_in;
            model[fr].imm  = disp_imme_in;
            model[fr].dest = disp_tag_in;
            model[fr].t1   = on_cdb(disp_rs1_tag_in) ? '0 : disp_rs1_tag_in;
            model[fr].v1   = on_cdb(disp_rs1_tag_in) ? cdb_value(disp_rs1_tag_in) : disp_rs1_val_in;
            model[fr].t2   = on_cdb(disp_rs2_tag_in) ? '0 : disp_rs2_tag_in;
            model[fr].v2   = on_cdb(disp_rs2_tag_in) ? cdb_value(disp_rs2_tag_in) : disp_rs2_val_in;
         end
      end
      exp_q.push_back('{cyc: edge_cnt + 1, o: o});
      last_out = o;
   endtask

   // Scoreboard monitor: compares the issue bundle at every falling edge it has a prediction for.
   always @(negedge clk_in) begin
      mon_act = {issue_tag_out, issue_inst_out, issue_npc_out,
                 issue_rs1_val_out, issue_rs2_val_out, issue_imme_out};
      if (exp_q.size() > 0 && exp_q[0].cyc <= edge_cnt) begin
         mon_exp = exp_q.pop_front();
         checks++;
         if (mon_exp.cyc != edge_cnt || mon_act !== mon_exp.o) begin
            failures++;
            $display("FAIL issue cyc=%0d got tag=%0d inst=%0d npc=%h rs1=%h rs2=%h imm=%h want tag=%0d inst=%0d npc=%h rs1=%h rs2=%h imm=%h",
                     edge_cnt, mon_act.tag, mon_act.inst, mon_act.npc, mon_act.v1, mon_act.v2, mon_act.imm,
                     mon_exp.o.tag, mon_exp.o.inst, mon_exp.o.npc, mon_exp.o.v1, mon_exp.o.v2, mon_exp.o.imm);
         end
      end else if (rst_in && issue_tag_out != 0) begin
         checks++;
         failures++;
         $display("FAIL unexpected_issue cyc=%0d got tag=%0d want none", edge_cnt, issue_tag_out);
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic step();
      checks++;
      if (full_out !== model_full()) begin
         failures++;
         $display("FAIL full_out cyc=%0d got=%b want=%b", edge_cnt, full_out, model_full());
      end
      model_step();
      @(negedge clk_in);
      #1;
   endtask

   task automatic idle();
      rdy_in = 1'b1; flush_in = 1'b0; disp_valid_in = 1'b0;
      alu_cdb_tag_in = '0; alu_cdb_val_in = '0; lsb_cdb_tag_in = '0; lsb_cdb_val_in = '0;
   endtask

   task automatic put(input logic [INST_W-1:0] inst, input logic [TAG_W-1:0] dest,
                      input logic [TAG_W-1:0] t1, input logic [REGVAL_W-1:0] v1,
                      input logic [TAG_W-1:0] t2, input logic [REGVAL_W-1:0] v2,
                      input logic [IMM_W-1:0] imm);
      disp_valid_in = 1'b1; disp_inst_in = inst; disp_tag_in = dest;
      disp_npc_in = 32'h1000 + {24'h0, 3'h0, dest} * 32'd4;
      disp_rs1_tag_in = t1; disp_rs1_val_in = v1;
      disp_rs2_tag_in = t2; disp_rs2_val_in = v2; disp_imme_in = imm;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) model[i] = '{default: '0};
      idle();
      put(INST_NOP, 5'd0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0);
      disp_valid_in = 1'b0;
      repeat (3) @(negedge clk_in);
      chk("reset_tag", {27'd0, issue_tag_out}, 32'd0);
      chk("reset_rs1", issue_rs1_val_out, 32'd0);
      chk("reset_full", {31'd0, full_out}, 32'd0);
      #1 rst_in = 1'b1;

      // Minimum-latency issue of a ready addi
      put(INST_ADDI, 5'd3, 5'd0, 32'd5, 5'd0, 32'd0, 32'd7); step(); idle();
      step();
      chk("t1_tag", {27'd0, issue_tag_out}, 32'd3);
      chk("t1_rs1", issue_rs1_val_out, 32'd5);
      chk("t1_imm", issue_imme_out, 32'd7);
      step();
      chk("t1_bubble", {27'd0, issue_tag_out}, 32'd0);

      // Wake-up on ALU CDB
      put(INST_ADD, 5'd4, 5'd0, 32'd1, 5'd2, 32'd0, 32'd0); step(); idle();
      step(); step();
      chk("t2_wait", {27'd0, issue_tag_out}, 32'd0);
      alu_cdb_tag_in = 5'd2; alu_cdb_val_in = 32'd9; step(); idle();
`ifdef RS_WAKE_BYPASS_EN
      chk("t2_fast_tag", {27'd0, issue_tag_out}, 32'd4);
      chk("t2_fast_rs2", issue_rs2_val_out, 32'd9);
      step();
`else
      chk("t2_early", {27'd0, issue_tag_out}, 32'd0);
      step();
      chk("t2_tag", {27'd0, issue_tag_out}, 32'd4);
      chk("t2_rs2", issue_rs2_val_out, 32'd9);
`endif

      // Dispatch-time bypass from LSB CDB
      put(INST_ADD, 5'd5, 5'd6, 32'h1111, 5'd0, 32'd2, 32'd0);
      lsb_cdb_tag_in = 5'd6; lsb_cdb_val_in = 32'hDEAD_BEEF; step(); idle();
      step();
      chk("t3_tag", {27'd0, issue_tag_out}, 32'd5);
      chk("t3_rs1", issue_rs1_val_out, 32'hDEAD_BEEF);

      // Fill, overflow, then drain in index order
      for (int i = 0; i < 16; i++) begin
         put(INST_ADDI, 5'(i + 1), 5'd7, 32'd0, 5'd0, 32'd3, 32'(i)); step();
      end
      idle();
      chk("t4_full", {31'd0, full_out}, 32'd1);
      put(INST_ADDI, 5'd20, 5'd0, 32'd8, 5'd0, 32'd0, 32'd0); step(); idle();
      chk("t4_still_full", {31'd0, full_out}, 32'd1);
      alu_cdb_tag_in = 5'd7; alu_cdb_val_in = 32'd77; step(); idle();
      step();
      chk("t4_full_drop", {31'd0, full_out}, 32'd0);
      repeat (16) step();

      // Flush with a simultaneous dispatch
      put(INST_ADD, 5'd10, 5'd9, 32'd0, 5'd0, 32'd0, 32'd0); step();
      put(INST_ADD, 5'd11, 5'd9, 32'd0, 5'd0, 32'd0, 32'd0); step();
      put(INST_ADDI, 5'd12, 5'd0, 32'd4, 5'd0, 32'd0, 32'd1); step();
      put(INST_ADDI, 5'd13, 5'd0, 32'd4, 5'd0, 32'd0, 32'd1); flush_in = 1'b1; step(); idle();
      chk("t5_tag", {27'd0, issue_tag_out}, 32'd0);
      chk("t5_full", {31'd0, full_out}, 32'd0);
      alu_cdb_tag_in = 5'd9; alu_cdb_val_in = 32'd1; step(); idle();
      repeat (3) step();

      // Stall with rdy_in low
      put(INST_ADD, 5'd15, 5'd11, 32'd0, 5'd0, 32'd0, 32'd0); step();
      put(INST_ADDI, 5'd14, 5'd0, 32'h66, 5'd0, 32'd0, 32'd2); step();
      put(INST_ADDI, 5'd16, 5'd0, 32'h67, 5'd0, 32'd0, 32'd3); step();
      put(INST_ADDI, 5'd17, 5'd0, 32'h68, 5'd0, 32'd0, 32'd4);
      rdy_in = 1'b0; alu_cdb_tag_in = 5'd11; alu_cdb_val_in = 32'h55;
      repeat (5) step();
      idle();
      chk("t6_hold", {27'd0, issue_tag_out}, 32'd14);
      step();
      chk("t6_resume", {27'd0, issue_tag_out}, 32'd16);
      step();
      chk("t6_missed", {27'd0, issue_tag_out}, 32'd0);
      alu_cdb_tag_in = 5'd11; alu_cdb_val_in = 32'h55; step(); idle();
      repeat (3) step();

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         idle();
         rdy_in = ($urandom_range(0, 9) != 0);
         flush_in = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 1) == 1) begin
            put(6'($urandom_range(1, 9)), 5'($urandom_range(1, 31)),
                ($urandom_range(0, 1) == 1) ? 5'($urandom_range(21, 24)) : 5'd0, $urandom,
                ($urandom_range(0, 1) == 1) ? 5'($urandom_range(21, 24)) : 5'd0, $urandom,
                $urandom);
         end
         if ($urandom_range(0, 2) == 0) begin
            alu_cdb_tag_in = 5'($urandom_range(21, 24)); alu_cdb_val_in = $urandom;
         end
         if ($urandom_range(0, 2) == 0) begin
            lsb_cdb_tag_in = 5'($urandom_range(21, 24)); lsb_cdb_val_in = $urandom;
            if (lsb_cdb_tag_in == alu_cdb_tag_in) lsb_cdb_tag_in = '0;
         end
         step();
      end

      idle();
      for (int t = 21; t <= 24; t++) begin
         alu_cdb_tag_in = 5'(t); alu_cdb_val_in = 32'(t * 3); step();
      end
      idle();
      repeat (20) step();
      chk("drain_queue", 32'(exp_q.size()), 32'd0);
      chk("drain_full", {31'd0, full_out}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rs_alu.md
Name: rs_alu

Overview:
- Reservation station in front of the ALU in the Tomasulo core.
- Accepts renamed ALU/branch instructions from dispatch and holds them until both operands are valid.
- Snoops the ALU and LSB common data buses (CDB) for operand wake-up.
- Issues one ready instruction per cycle on the ALU input bundle (inst, npc, rs1/rs2 values, imm, ROB tag).

Parameters:
- DEPTH, 16, number of entries (power of two, ≥2).
- IDX_W, 4, log2(DEPTH).

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global enable; when 0, all state freezes.
- flush_in  input  1  mispredict clear from ROB.
- disp_valid_in  input  1  dispatch request.
- disp_inst_in  input  InstBus  decoded instruction code.
- disp_npc_in  input  AddrBus  pc+4 of the instruction.
- disp_imme_in  input  ImmediateBus  immediate.
- disp_tag_in  input  ROBTagBus  destination ROB tag (never 0).
- disp_rs1_val_in / disp_rs2_val_in  input  RegValBus  operand values, meaningful when the matching tag is 0.
- disp_rs1_tag_in / disp_rs2_tag_in  input  ROBTagBus  producer tags; 0 = value already ready.
- full_out  output  1  no free entry.
- alu_cdb_tag_in  input  ROBTagBus  ALU broadcast tag; 0 = idle.
- alu_cdb_val_in  input  RegValBus  ALU broadcast value.
- lsb_cdb_tag_in  input  ROBTagBus  LSB broadcast tag; 0 = idle.
- lsb_cdb_val_in  input  RegValBus  LSB broadcast value.
- issue_inst_out  output  InstBus  to ALU.
- issue_npc_out  output  AddrBus  to ALU.
- issue_rs1_val_out  output  RegValBus  to ALU.
- issue_rs2_val_out  output  RegValBus  to ALU.
- issue_imme_out  output  ImmediateBus  to ALU.
- issue_tag_out  output  ROBTagBus  to ALU; 0 = bubble.

Behaviour:
- Reset (rst_in=0, async):
  - All entry valid bits cleared.
  - full_out=0.
  - All issue_* outputs = 0.
- Entry state: valid, inst, npc, imme, dest tag, and per operand {tag, val}. An operand is ready when its tag is 0.
- rdy_in=0: no register changes; outputs hold their values.
- Dispatch (disp_valid_in=1, full_out=0):
  - Writes the lowest-index free entry at the clock edge.
  - A dispatch with full_out=1 is ignored.
  - full_out is combinational from registered valid bits only; an issue in the same cycle does not clear it.
- Wake-up, every cycle, for each valid entry and each non-ready operand:
  - If the operand tag equals a non-zero alu_cdb_tag_in or lsb_cdb_tag_in, capture the value and clear the tag.
  - The ALU bus takes precedence if both buses match (cannot occur legally).
- Dispatch-time bypass: an incoming operand tag that matches a CDB tag in the same cycle is stored ready with the CDB value.
- Select:
  - Eligible entry = valid and both operand tags are 0 in registered state.
  - The lowest-index eligible entry is chosen.
  - At the edge: issue_* registers load that entry's fields and the entry's valid bit clears.
  - If nothing is eligible, issue_tag_out=0 and all other issue_* outputs = 0 (bubble).
- Issue timing:
  - Minimum latency from dispatch with ready operands to issue_* valid is 2 edges: dispatch edge, then issue edge.
  - An operand woken in cycle N makes its entry eligible in cycle N+1.
- One issue per cycle. Dispatch, wake-up and issue may all occur in the same cycle on different entries.
- The issuing entry's slot is free for dispatch from the following cycle.
- Flush (flush_in=1, rdy_in=1):
  - At the edge: all valid bits clear and issue_* are zeroed; dispatch and issue in that cycle are discarded.
  - flush_in dominates dispatch.
- Tag wrap: tags are compared for equality only; there is no age ordering.

Optional Feature:
- Macro: RS_WAKE_BYPASS_EN.
- When defined: an entry whose last missing operand matches a CDB tag in cycle N is eligible in cycle N. The CDB value is forwarded directly into issue_rs*_val_out, cutting wake-to-issue latency by one cycle.
- When undefined: behaviour is exactly as specified in Behaviour (eligible in N+1).

Decomposition:
- Shared constants header (existing constant include) supplies:
  - InstBus, AddrBus, RegValBus, ImmediateBus and ROBTagBus widths.
  - The instruction codes.
  - A new NoTag=0 define.
- One sub-module: rs_select, a DEPTH-wide lowest-index priority encoder returning {found, idx}. It is instantiated twice: once for the free-slot search, once for the eligible-entry search.

Test Plan:
1. Reset, then dispatch addi, tag 3, rs1 ready val 5, imm 7 -> two edges later: issue_tag_out=3, issue_rs1_val_out=5, issue_imme_out=7; the following cycle issue_tag_out=0.
2. Dispatch add, tag 4, rs1 ready val 1, rs2_tag 2 -> no issue; ALU CDB tag 2 val 9 at cycle N -> issue at edge N+2 with rs2_val=9 (N+1 when RS_WAKE_BYPASS_EN is defined).
3. Dispatch with rs1_tag 6 while lsb_cdb_tag_in=6, val 0xDEAD_BEEF -> entry stored ready; issues with rs1_val=0xDEADBEEF.
4. Fill 16 entries, all waiting on tag 7 -> full_out=1 and a 17th dispatch is ignored; broadcast tag 7 -> issues in index order 0..15, one per cycle; full_out drops after the first issue.
5. Three entries valid, one eligible; assert flush_in with a simultaneous dispatch -> the next cycle has all entries empty, issue_tag_out=0, full_out=0, and nothing issues afterwards.
6. Hold rdy_in=0 for 5 cycles with an eligible entry and CDB activity -> outputs and entries unchanged, and CDB data is missed; on rdy_in=1 the entry issues normally.
